// File: rtl/pipelined_alu_unit.sv
// Pipelined EX-stage ALU: single-cycle simple ops, iterative MUL/MULHU,
// valid/ready handshake on both sides, registered result and branch flag.
module pipelined_alu_unit #(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned MUL_BITS_PER_CYC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] alu_in_1,
    input  logic [XLEN-1:0] alu_in_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_bcond
);

    localparam int unsigned K  = MUL_BITS_PER_CYC;
    localparam int unsigned C  = XLEN / K;
    localparam int unsigned SH = $clog2(XLEN);
    localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned AW = 2 * XLEN;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_XOR   = 5'd3;
    localparam logic [4:0] OP_OR    = 5'd4;
    localparam logic [4:0] OP_AND   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_BEQ   = 5'd10;
    localparam logic [4:0] OP_BNE   = 5'd11;
    localparam logic [4:0] OP_BLT   = 5'd12;
    localparam logic [4:0] OP_BGE   = 5'd13;
    localparam logic [4:0] OP_BLTU  = 5'd14;
    localparam logic [4:0] OP_BGEU  = 5'd15;
    localparam logic [4:0] OP_MUL   = 5'd16;
    localparam logic [4:0] OP_MULHU = 5'd17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]   mul_cnt;
    logic [AW-1:0]   mul_acc;
    logic [AW-1:0]   mul_a_sh;
    logic [XLEN-1:0] mul_b_sh;
    logic            mul_hi;

    logic            accept;
    logic            is_mul_op;
    logic            mul_last;
    logic [XLEN-1:0] simple_res;
    logic            simple_bcond;
    logic [AW-1:0]   mul_partial;
    logic [AW-1:0]   mul_acc_next;

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [SH-1:0]   shamt;
    logic            lt_s;
    logic            lt_u;
    logic            eq;

    assign accept    = in_valid & in_ready & ~flush;
    assign is_mul_op = (alu_op == OP_MUL) || (alu_op == OP_MULHU);
    assign mul_last  = (mul_cnt == CW'(C - 1));

    // State register; handshake flags follow the next state so they are registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == S_IDLE);
            out_valid <= (next_state == S_DONE);
        end
    end

    // Next-state logic; flush forces IDLE from any state
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) next_state = is_mul_op ? S_MUL : S_DONE;
            end
            S_MUL: begin
                if (mul_last) next_state = S_DONE;
            end
            S_DONE: begin
                if (out_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        if (flush) next_state = S_IDLE;
    end

    // Output/datapath values: simple-op result, branch flag, multiply step
    always_comb begin
        sum          = alu_in_1 + alu_in_2;
        diff         = alu_in_1 - alu_in_2;
        shamt        = alu_in_2[SH-1:0];
        lt_s         = $signed(alu_in_1) < $signed(alu_in_2);
        lt_u         = alu_in_1 < alu_in_2;
        eq           = (alu_in_1 == alu_in_2);
        simple_res   = '0;
        simple_bcond = 1'b0;
        case (alu_op)
            OP_ADD:  simple_res = sum;
            OP_SUB:  simple_res = diff;
            OP_SLL:  simple_res = alu_in_1 << shamt;
            OP_XOR:  simple_res = alu_in_1 ^ alu_in_2;
            OP_OR:   simple_res = alu_in_1 | alu_in_2;
            OP_AND:  simple_res = alu_in_1 & alu_in_2;
            OP_SRL:  simple_res = alu_in_1 >> shamt;
            OP_SRA:  simple_res = $signed(alu_in_1) >>> shamt;
            OP_SLT:  simple_res = XLEN'(lt_s);
            OP_SLTU: simple_res = XLEN'(lt_u);
            OP_BEQ:  begin simple_res = diff; simple_bcond = eq;    end
            OP_BNE:  begin simple_res = diff; simple_bcond = ~eq;   end
            OP_BLT:  begin simple_res = diff; simple_bcond = lt_s;  end
            OP_BGE:  begin simple_res = diff; simple_bcond = ~lt_s; end
            OP_BLTU: begin simple_res = diff; simple_bcond = lt_u;  end
            OP_BGEU: begin simple_res = diff; simple_bcond = ~lt_u; end
            default: begin simple_res = '0; simple_bcond = 1'b0;    end
        endcase

        // Shift-and-add over the next K multiplier bits
        mul_partial = '0;
        for (int unsigned j = 0; j < K; j++) begin
            if (mul_b_sh[j]) mul_partial = mul_partial + (mul_a_sh << j);
        end
        mul_acc_next = mul_acc + mul_partial;
    end

    // Datapath registers: result/flag capture and multiplier iteration state
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result <= '0;
            alu_bcond  <= 1'b0;
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_a_sh   <= '0;
            mul_b_sh   <= '0;
            mul_hi     <= 1'b0;
        end else if (!flush) begin
            if (state == S_IDLE && accept) begin
                if (is_mul_op) begin
                    mul_cnt   <= '0;
                    mul_acc   <= '0;
                    mul_a_sh  <= {{XLEN{1'b0}}, alu_in_1};
                    mul_b_sh  <= alu_in_2;
                    mul_hi    <= (alu_op == OP_MULHU);
                    alu_bcond <= 1'b0;
                end else begin
                    alu_result <= simple_res;
                    alu_bcond  <= simple_bcond;
                end
            end else if (state == S_MUL) begin
                mul_cnt  <= mul_cnt + CW'(1);
                mul_acc  <= mul_acc_next;
                mul_a_sh <= mul_a_sh << K;
                mul_b_sh <= mul_b_sh >> K;
                if (mul_last) begin
                    alu_result <= mul_hi ? mul_acc_next[AW-1:XLEN] : mul_acc_next[XLEN-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_alu_unit.sv
// Scoreboard bench for pipelined_alu_unit: K=1 and K=4 instances share inputs,
// sel routes in_valid and picks which instance is observed.
module tb_pipelined_alu_unit;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            bc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_ready;
    logic            sel;

    logic            ir1, ov1, bc1, ir4, ov4, bc4;
    logic [XLEN-1:0] res1, res4;
    logic            iv1, iv4;
    logic            ir, ov, bc;
    logic [XLEN-1:0] res;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign iv1 = in_valid & ~sel;
    assign iv4 = in_valid & sel;
    assign ir  = sel ? ir4  : ir1;
    assign ov  = sel ? ov4  : ov1;
    assign bc  = sel ? bc4  : bc1;
    assign res = sel ? res4 : res1;

    pipelined_alu_unit #(.XLEN(XLEN), .MUL_BITS_PER_CYC(1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .alu_op(alu_op),
        .alu_in_1(a), .alu_in_2(b),
        .out_valid(ov1), .out_ready(out_ready),
        .alu_result(res1), .alu_bcond(bc1)
    );

    pipelined_alu_unit #(.XLEN(XLEN), .MUL_BITS_PER_CYC(4)) u_dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv4), .in_ready(ir4), .alu_op(alu_op),
        .alu_in_1(a), .alu_in_2(b),
        .out_valid(ov4), .out_ready(out_ready),
        .alu_result(res4), .alu_bcond(bc4)
    );

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops one expected response
    always @(negedge clk) begin
        if (!reset && !flush && ov && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got 0x%08h want none", res);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", res, e.res);
                check("sb_bcond", XLEN'(bc), XLEN'(e.bc));
            end
        end
    end

    // Issue one op, check latency, optionally stall the consumer for `hold` cycles
    task automatic issue(input string name, input logic [4:0] op, input logic [XLEN-1:0] x,
                         input logic [XLEN-1:0] y, input logic [XLEN-1:0] er, input logic eb,
                         input int lat, input int hold);
        int cnt;
        @(negedge clk);
        alu_op = op; a = x; b = y; in_valid = 1'b1;
        check({name, "_in_ready"}, XLEN'(ir), XLEN'(1));
        @(posedge clk);
        sb.push_back('{res: er, bc: eb});
        #1 in_valid = 1'b0;
        cnt = 0;
        while (!ov && cnt < 100) begin
            @(posedge clk);
            #1 cnt++;
        end
        check({name, "_latency"}, XLEN'(cnt), XLEN'(lat));
        if (cnt >= 100) return;
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                check({name, "_hold_valid"}, XLEN'(ov), XLEN'(1));
                check({name, "_hold_result"}, res, er);
                check({name, "_hold_in_ready"}, XLEN'(ir), XLEN'(0));
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({name, "_valid_drop"}, XLEN'(ov), XLEN'(0));
        check({name, "_back_idle"}, XLEN'(ir), XLEN'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_op = '0;
        a = '0; b = '0; out_ready = 1'b1; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", XLEN'(ir), XLEN'(1));
        check("rst_out_valid", XLEN'(ov), XLEN'(0));
        check("rst_result", res, '0);
        check("rst_bcond", XLEN'(bc), XLEN'(0));
        reset = 1'b0;

        // Simple ops, K=1 instance
        issue("add",   5'd0,  32'd5,          32'd7,          32'd12,         1'b0, 0, 0);
        issue("sub",   5'd1,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 0, 0);
        issue("blt",   5'd12, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1, 0, 0);
        issue("bgeu",  5'd15, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1, 0, 0);
        issue("bge",   5'd13, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 0, 0);
        issue("bltu",  5'd14, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 0, 0);
        issue("blt_ov",5'd12, 32'h7FFF_FFFF,  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 0, 0);
        issue("beq",   5'd10, 32'd5,          32'd5,          32'd0,          1'b1, 0, 0);
        issue("bne",   5'd11, 32'd5,          32'd5,          32'd0,          1'b0, 0, 0);
        issue("sll",   5'd2,  32'd1,          32'd33,         32'd2,          1'b0, 0, 0);
        issue("sra",   5'd7,  32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 0, 0);
        issue("srl",   5'd6,  32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 0, 0);
        issue("slt",   5'd8,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 0, 0);
        issue("sltu",  5'd9,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 0, 0);
        issue("xor",   5'd3,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFF00_FF00,  1'b0, 0, 0);
        issue("or",    5'd4,  32'hF0F0_F0F0,  32'h0F0F_0000,  32'hFFFF_F0F0,  1'b0, 0, 0);
        issue("and",   5'd5,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 0, 0);
        issue("illegal",5'd20,32'd9,          32'd4,          32'd0,          1'b0, 0, 0);

        // Multiplies, K=1: C=32
        issue("mul1",   5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,          1'b0, 32, 0);
        issue("mulhu1", 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,  1'b0, 32, 0);
        issue("mul1b",  5'd16, 32'h1234_5678, 32'h10,        32'h2345_6780,  1'b0, 32, 0);
        issue("mulhu1b",5'd17, 32'h1234_5678, 32'h10,        32'd1,          1'b0, 32, 0);

        // Multiplies, K=4: C=8
        sel = 1'b1;
        issue("mul4",   5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,          1'b0, 8, 0);
        issue("mulhu4", 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,  1'b0, 8, 0);
        issue("mul4b",  5'd16, 32'h1234_5678, 32'h10,        32'h2345_6780,  1'b0, 8, 0);
        sel = 1'b0;

        // Consumer stall in DONE
        out_ready = 1'b0;
        issue("hold_xor", 5'd3, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA, 1'b0, 0, 3);

        // Flush during MUL cycle 10
        @(negedge clk);
        alu_op = 5'd16; a = 32'd3; b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_mul_valid", XLEN'(ov), XLEN'(0));
        check("flush_mul_idle", XLEN'(ir), XLEN'(1));
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov) seen++;
        end
        check("flush_mul_no_output", XLEN'(seen), XLEN'(0));

        // Flush together with in_valid in IDLE: not accepted
        @(negedge clk);
        alu_op = 5'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_in_ready", XLEN'(ir), XLEN'(1));
        check("flush_idle_valid", XLEN'(ov), XLEN'(0));

        // Flush in DONE with out_ready: no handoff
        out_ready = 1'b0;
        @(negedge clk);
        alu_op = 5'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("done_reached", XLEN'(ov), XLEN'(1));
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_done_valid", XLEN'(ov), XLEN'(0));
        check("flush_done_idle", XLEN'(ir), XLEN'(1));

        // Reset mid-MUL returns to reset values
        @(negedge clk);
        alu_op = 5'd17; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_mul_in_ready", XLEN'(ir), XLEN'(1));
        check("rst_mul_valid", XLEN'(ov), XLEN'(0));
        check("rst_mul_result", res, '0);
        check("rst_mul_bcond", XLEN'(bc), XLEN'(0));
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov) seen++;
        end
        check("rst_mul_no_output", XLEN'(seen), XLEN'(0));

        repeat (3) @(posedge clk);
        check("sb_drained", XLEN'(sb.size()), XLEN'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
